// File: rtl/rtb_pkg.sv
// rtb_pkg: shared constants and elaboration-time helpers for the real-time
// timebase (real_time_base) and its sub-blocks.
//   SEC_PER_MIN : seconds per minute (second counter modulus)
//   MS_W, SEC_W : widths of the ms-of-second and second-of-minute fields
//   clog2       : ceiling log2, never less than 1 (sizes the prescaler)
//   params_ok   : legality check of the top-level parameter set
package rtb_pkg;

  localparam int SEC_PER_MIN = 60;
  localparam int MS_W        = 10;
  localparam int SEC_W       = 6;

  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

  // The clock must divide evenly into base ticks, the prescaler needs at
  // least two states, and the ms field must fit in MS_W bits.
  function automatic bit params_ok(input int clk_hz, input int tick_hz,
                                   input int ticks_per_sec, input int min_w);
    if (tick_hz <= 0) return 1'b0;
    if ((clk_hz % tick_hz) != 0) return 1'b0;
    return ((clk_hz / tick_hz) >= 2) && (ticks_per_sec >= 1) &&
           (ticks_per_sec <= (1 << MS_W)) && (min_w >= 1) && (min_w <= 30);
  endfunction

endpackage

// File: rtl/real_time_base_if.sv
// real_time_base_if: event-timestamp capture port of the timebase.
//   EVENT        : single-cycle capture strobe (consumer -> timebase)
//   SNAP_ACK     : snapshot acknowledge         (consumer -> timebase)
//   SNAP_SUB     : captured prescaler value     (timebase -> consumer)
//   SNAP_MS/SEC/MIN : captured time fields      (timebase -> consumer)
//   SNAP_VALID   : snapshot holds unread data
//   SNAP_OVERRUN : an EVENT was dropped while SNAP_VALID was high
// The timebase uses the slave modport, the consumer the master modport.
interface real_time_base_if #(
  parameter int SUB_W = 2,
  parameter int MIN_W = 16
);
  import rtb_pkg::*;

  logic                EVENT;
  logic                SNAP_ACK;
  logic [SUB_W-1:0]    SNAP_SUB;
  logic [MS_W-1:0]     SNAP_MS;
  logic [SEC_W-1:0]    SNAP_SEC;
  logic [MIN_W-1:0]    SNAP_MIN;
  logic                SNAP_VALID;
  logic                SNAP_OVERRUN;

  modport slave (
    input  EVENT, SNAP_ACK,
    output SNAP_SUB, SNAP_MS, SNAP_SEC, SNAP_MIN, SNAP_VALID, SNAP_OVERRUN
  );

  modport master (
    output EVENT, SNAP_ACK,
    input  SNAP_SUB, SNAP_MS, SNAP_SEC, SNAP_MIN, SNAP_VALID, SNAP_OVERRUN
  );
endinterface

// File: rtl/mod_n_counter.sv
// mod_n_counter: modulo-N counter with saturating parallel load.
//   CLK, RST : clock, synchronous active-high reset
//   INC      : advance by one (wraps N-1 -> 0)
//   LOAD     : load LOAD_VAL, clamped to N-1; has priority over INC
//   CNT      : current count
//   WRAP     : high in the cycle where an increment takes N-1 -> 0
module mod_n_counter #(
  parameter int N     = 10,
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INC,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] CNT,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(N - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (LOAD) begin
      cnt_d = (LOAD_VAL > MAX) ? MAX : LOAD_VAL;
    end else if (INC) begin
      cnt_d = (cnt_q == MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples its pre-edge inputs, independent of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign CNT  = cnt_q;
  assign WRAP = INC && !LOAD && (cnt_q == MAX);

endmodule

// File: rtl/real_time_base.sv
// real_time_base: clock prescaler cascaded into ms / second / minute counters,
// with tick pulses, toggle outputs, software load and an event timestamp.
//   CLK, RST          : clock, synchronous active-high reset (overrides all)
//   EN                : count enable; counters and *_SQ hold when low
//   SET, SET_MS/SEC/MIN : single-cycle load of the time value (saturating)
//   MS/SEC/MIN_TICK   : one-cycle pulses, coincident with the counting edge
//   MS/SEC/MIN_SQ     : toggle once per corresponding tick
//   CNT_MS/SEC/MIN    : current time
//   snap              : EVENT capture with valid/ack handshake (slave side)
module real_time_base
  import rtb_pkg::*;
#(
  parameter int CLK_HZ        = 9600000,
  parameter int TICK_HZ       = 1000,
  parameter int TICKS_PER_SEC = 1000,
  parameter int MIN_WIDTH     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 SET,
  input  logic [MS_W-1:0]      SET_MS,
  input  logic [SEC_W-1:0]     SET_SEC,
  input  logic [MIN_WIDTH-1:0] SET_MIN,
  real_time_base_if.slave      snap,
  output logic                 MS_TICK,
  output logic                 SEC_TICK,
  output logic                 MIN_TICK,
  output logic                 MS_SQ,
  output logic                 SEC_SQ,
  output logic                 MIN_SQ,
  output logic [MS_W-1:0]      CNT_MS,
  output logic [SEC_W-1:0]     CNT_SEC,
  output logic [MIN_WIDTH-1:0] CNT_MIN
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int SUB_W = clog2(DIV);

  if (!params_ok(CLK_HZ, TICK_HZ, TICKS_PER_SEC, MIN_WIDTH)) begin : g_param_error
    $error("real_time_base: illegal CLK_HZ/TICK_HZ/TICKS_PER_SEC/MIN_WIDTH");
  end

  // ---------------- counter cascade ----------------
  logic                 run;
  logic [SUB_W-1:0]     pre_cnt;
  logic                 ms_tick;
  logic                 sec_tick;
  logic                 min_tick;
  logic                 min_wrap_unused;

  // A load cycle and a reset cycle never count, so no tick can fire in them.
  assign run = EN && !SET && !RST;

  mod_n_counter #(.N(DIV), .WIDTH(SUB_W)) u_prescaler (
    .CLK(CLK), .RST(RST), .INC(run), .LOAD(SET), .LOAD_VAL('0),
    .CNT(pre_cnt), .WRAP(ms_tick)
  );

  mod_n_counter #(.N(TICKS_PER_SEC), .WIDTH(MS_W)) u_ms (
    .CLK(CLK), .RST(RST), .INC(ms_tick), .LOAD(SET), .LOAD_VAL(SET_MS),
    .CNT(CNT_MS), .WRAP(sec_tick)
  );

  mod_n_counter #(.N(SEC_PER_MIN), .WIDTH(SEC_W)) u_sec (
    .CLK(CLK), .RST(RST), .INC(sec_tick), .LOAD(SET), .LOAD_VAL(SET_SEC),
    .CNT(CNT_SEC), .WRAP(min_tick)
  );

  // Free-running minutes: the wrap is silent, so its pulse is left unused.
  mod_n_counter #(.N(1 << MIN_WIDTH), .WIDTH(MIN_WIDTH)) u_min (
    .CLK(CLK), .RST(RST), .INC(min_tick), .LOAD(SET), .LOAD_VAL(SET_MIN),
    .CNT(CNT_MIN), .WRAP(min_wrap_unused)
  );

  assign MS_TICK  = ms_tick;
  assign SEC_TICK = sec_tick;
  assign MIN_TICK = min_tick;

  // ---------------- square outputs ----------------
  logic [2:0] sq_q;   // {min, sec, ms}
  logic [2:0] sq_d;

  assign sq_d = sq_q ^ {min_tick, sec_tick, ms_tick};

  always_ff @(posedge CLK) begin
    if (RST) sq_q <= '0;
    else     sq_q <= sq_d;
  end

  assign MS_SQ  = sq_q[0];
  assign SEC_SQ = sq_q[1];
  assign MIN_SQ = sq_q[2];

  // ---------------- event capture ----------------
  logic                 snap_valid_q, snap_valid_d;
  logic                 snap_ovr_q,   snap_ovr_d;
  logic [SUB_W-1:0]     snap_sub_q,   snap_sub_d;
  logic [MS_W-1:0]      snap_ms_q,    snap_ms_d;
  logic [SEC_W-1:0]     snap_sec_q,   snap_sec_d;
  logic [MIN_WIDTH-1:0] snap_min_q,   snap_min_d;

  // A capture is allowed when the slot is free or being freed in this same
  // cycle; the sampled values are the pre-edge ones, so a simultaneous SET
  // or count is not yet visible.
  always_comb begin
    snap_valid_d = snap_valid_q;
    snap_ovr_d   = snap_ovr_q;
    snap_sub_d   = snap_sub_q;
    snap_ms_d    = snap_ms_q;
    snap_sec_d   = snap_sec_q;
    snap_min_d   = snap_min_q;
    if (snap.EVENT && (!snap_valid_q || snap.SNAP_ACK)) begin
      snap_sub_d   = pre_cnt;
      snap_ms_d    = CNT_MS;
      snap_sec_d   = CNT_SEC;
      snap_min_d   = CNT_MIN;
      snap_valid_d = 1'b1;
      snap_ovr_d   = 1'b0;
    end else if (snap.SNAP_ACK && snap_valid_q) begin
      snap_valid_d = 1'b0;
      snap_ovr_d   = 1'b0;
    end else if (snap.EVENT) begin
      // Only reachable while valid and unacknowledged: drop and flag.
      snap_ovr_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      snap_valid_q <= 1'b0;
      snap_ovr_q   <= 1'b0;
      snap_sub_q   <= '0;
      snap_ms_q    <= '0;
      snap_sec_q   <= '0;
      snap_min_q   <= '0;
    end else begin
      snap_valid_q <= snap_valid_d;
      snap_ovr_q   <= snap_ovr_d;
      snap_sub_q   <= snap_sub_d;
      snap_ms_q    <= snap_ms_d;
      snap_sec_q   <= snap_sec_d;
      snap_min_q   <= snap_min_d;
    end
  end

  assign snap.SNAP_VALID   = snap_valid_q;
  assign snap.SNAP_OVERRUN = snap_ovr_q;
  assign snap.SNAP_SUB     = snap_sub_q;
  assign snap.SNAP_MS      = snap_ms_q;
  assign snap.SNAP_SEC     = snap_sec_q;
  assign snap.SNAP_MIN     = snap_min_q;

endmodule

// File: tb/tb_real_time_base.sv
// tb_real_time_base: randomized and directed stimulus for real_time_base.
// The reference model keeps time as one integer count of clock cycles and
// derives every field and tick from it with division and modulo; expected
// outputs are queued per cycle and compared by an independent monitor.
module tb_real_time_base;
  import rtb_pkg::*;

  localparam int CLK_HZ    = 40;
  localparam int TICK_HZ   = 10;
  localparam int TPS       = 10;
  localparam int MIN_WIDTH = 4;
  localparam int DIV       = CLK_HZ / TICK_HZ;
  localparam int SUB_W     = clog2(DIV);
  localparam int T_MS      = DIV;
  localparam int T_SEC     = DIV * TPS;
  localparam int T_MIN     = T_SEC * SEC_PER_MIN;
  localparam int T_WRAP    = T_MIN * (1 << MIN_WIDTH);

  logic                 CLK;
  logic                 RST;
  logic                 EN;
  logic                 SET;
  logic [MS_W-1:0]      SET_MS;
  logic [SEC_W-1:0]     SET_SEC;
  logic [MIN_WIDTH-1:0] SET_MIN;
  logic                 MS_TICK, SEC_TICK, MIN_TICK;
  logic                 MS_SQ, SEC_SQ, MIN_SQ;
  logic [MS_W-1:0]      CNT_MS;
  logic [SEC_W-1:0]     CNT_SEC;
  logic [MIN_WIDTH-1:0] CNT_MIN;

  real_time_base_if #(.SUB_W(SUB_W), .MIN_W(MIN_WIDTH)) snap_if ();

  real_time_base #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .TICKS_PER_SEC(TPS), .MIN_WIDTH(MIN_WIDTH)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .SET(SET),
    .SET_MS(SET_MS), .SET_SEC(SET_SEC), .SET_MIN(SET_MIN),
    .snap(snap_if),
    .MS_TICK(MS_TICK), .SEC_TICK(SEC_TICK), .MIN_TICK(MIN_TICK),
    .MS_SQ(MS_SQ), .SEC_SQ(SEC_SQ), .MIN_SQ(MIN_SQ),
    .CNT_MS(CNT_MS), .CNT_SEC(CNT_SEC), .CNT_MIN(CNT_MIN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] ticks;   // {min, sec, ms}
    logic [2:0] sq;      // {min, sec, ms}
    int         ms, sec, mnt;
    logic       valid, ovr;
    int         s_sub, s_ms, s_sec, s_min;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: elapsed clock cycles since 00:00.000 modulo the minute
  // counter range, plus toggles and the snapshot slot.
  int         m_t;
  logic [2:0] m_sq;
  logic       m_valid, m_ovr;
  int         m_sub, m_ms, m_sec, m_min;

  function automatic int f_sub(input int t); return t % DIV; endfunction
  function automatic int f_ms (input int t); return (t / T_MS) % TPS; endfunction
  function automatic int f_sec(input int t); return (t / T_SEC) % SEC_PER_MIN; endfunction
  function automatic int f_min(input int t); return t / T_MIN; endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, queue the outputs
  // expected during this cycle, then advance the model across the next edge.
  task automatic step(input bit rst, input bit en, input bit set,
                      input int sms, input int ssec, input int smin,
                      input bit ev, input bit ack);
    exp_t e;
    bit   cnt;
    int   ld_ms, ld_sec;
    @(posedge CLK);
    #1;
    RST = rst; EN = en; SET = set;
    SET_MS = MS_W'(sms); SET_SEC = SEC_W'(ssec); SET_MIN = MIN_WIDTH'(smin);
    snap_if.EVENT = ev; snap_if.SNAP_ACK = ack;

    cnt     = !rst && en && !set;
    e.ticks = {cnt && (m_t % T_MIN == T_MIN - 1),
               cnt && (m_t % T_SEC == T_SEC - 1),
               cnt && (m_t % T_MS  == T_MS  - 1)};
    e.sq    = m_sq;
    e.ms    = f_ms(m_t);  e.sec = f_sec(m_t); e.mnt = f_min(m_t);
    e.valid = m_valid;    e.ovr = m_ovr;
    e.s_sub = m_sub; e.s_ms = m_ms; e.s_sec = m_sec; e.s_min = m_min;
    q.push_back(e);

    if (rst) begin
      m_t = 0; m_sq = '0; m_valid = 1'b0; m_ovr = 1'b0;
      m_sub = 0; m_ms = 0; m_sec = 0; m_min = 0;
    end else begin
      // Snapshot slot: free (or freed now) -> take the pre-edge time;
      // occupied and not released -> drop and flag; bare release -> empty.
      if (ev && (!m_valid || ack)) begin
        m_sub = f_sub(m_t); m_ms = f_ms(m_t); m_sec = f_sec(m_t); m_min = f_min(m_t);
        m_valid = 1'b1; m_ovr = 1'b0;
      end else if (ev && m_valid) begin
        m_ovr = 1'b1;
      end else if (ack && m_valid) begin
        m_valid = 1'b0; m_ovr = 1'b0;
      end
      if (set) begin
        ld_ms  = (sms  > TPS - 1) ? TPS - 1 : sms;
        ld_sec = (ssec > SEC_PER_MIN - 1) ? SEC_PER_MIN - 1 : ssec;
        m_t    = ((smin * SEC_PER_MIN + ld_sec) * TPS + ld_ms) * DIV;
      end else if (en) begin
        m_sq = m_sq ^ e.ticks;
        m_t  = (m_t + 1) % T_WRAP;
      end
    end
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) step(1'b0, en, 1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    #1;
  endtask

  // Monitor: compares every queued cycle at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ms_tick",      32'(MS_TICK),  32'(e.ticks[0]));
        check("sec_tick",     32'(SEC_TICK), 32'(e.ticks[1]));
        check("min_tick",     32'(MIN_TICK), 32'(e.ticks[2]));
        check("ms_sq",        32'(MS_SQ),    32'(e.sq[0]));
        check("sec_sq",       32'(SEC_SQ),   32'(e.sq[1]));
        check("min_sq",       32'(MIN_SQ),   32'(e.sq[2]));
        check("cnt_ms",       32'(CNT_MS),   e.ms);
        check("cnt_sec",      32'(CNT_SEC),  e.sec);
        check("cnt_min",      32'(CNT_MIN),  e.mnt);
        check("snap_valid",   32'(snap_if.SNAP_VALID),   32'(e.valid));
        check("snap_overrun", 32'(snap_if.SNAP_OVERRUN), 32'(e.ovr));
        check("snap_sub",     32'(snap_if.SNAP_SUB),     e.s_sub);
        check("snap_ms",      32'(snap_if.SNAP_MS),      e.s_ms);
        check("snap_sec",     32'(snap_if.SNAP_SEC),     e.s_sec);
        check("snap_min",     32'(snap_if.SNAP_MIN),     e.s_min);
      end
    end
  end

  initial begin
    RST = 1'b1; EN = 1'b0; SET = 1'b0;
    SET_MS = '0; SET_SEC = '0; SET_MIN = '0;
    snap_if.EVENT = 1'b0; snap_if.SNAP_ACK = 1'b0;
    m_t = 0; m_sq = '0; m_valid = 1'b0; m_ovr = 1'b0;
    m_sub = 0; m_ms = 0; m_sec = 0; m_min = 0;
    repeat (2) @(posedge CLK);

    // First ms tick on the fourth enabled cycle; reset mid-count.
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    run(3, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    #1 check("dir_first_ms_tick", 32'(MS_TICK), 1);
    idle();
    check("dir_ms_after_tick", 32'(CNT_MS), 1);
    check("dir_ms_sq_after_tick", 32'(MS_SQ), 1);
    run(2, 1'b1);
    step(1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    idle();
    check("dir_rst_cnt_ms", 32'(CNT_MS), 0);
    check("dir_rst_ms_sq", 32'(MS_SQ), 0);

    // One full second, then a long hold with EN low.
    run(40, 1'b1);
    idle();
    check("dir_sec_cnt_sec", 32'(CNT_SEC), 1);
    check("dir_sec_cnt_ms", 32'(CNT_MS), 0);
    check("dir_sec_sq", 32'(SEC_SQ), 1);
    run(10, 1'b0);

    // All three ticks coincide at the end of the minute range.
    step(1'b0, 1'b1, 1'b1, 9, 59, 15, 1'b0, 1'b0);
    run(3, 1'b1);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    #1 check("dir_triple_tick", 32'({MIN_TICK, SEC_TICK, MS_TICK}), 32'h7);
    idle();
    check("dir_wrap_min", 32'(CNT_MIN), 0);
    check("dir_wrap_sec", 32'(CNT_SEC), 0);
    check("dir_wrap_ms", 32'(CNT_MS), 0);

    // Saturating load suppresses the tick that would otherwise fire.
    run(3, 1'b1);
    step(1'b0, 1'b1, 1'b1, 12, 63, 3, 1'b0, 1'b0);
    #1 check("dir_set_no_tick", 32'(MS_TICK), 0);
    idle();
    check("dir_sat_ms", 32'(CNT_MS), 9);
    check("dir_sat_sec", 32'(CNT_SEC), 59);

    // Capture, overrun, acknowledge.
    step(1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    run(14, 1'b1);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle();
    check("dir_cap_sub", 32'(snap_if.SNAP_SUB), 2);
    check("dir_cap_ms", 32'(snap_if.SNAP_MS), 3);
    check("dir_cap_valid", 32'(snap_if.SNAP_VALID), 1);
    step(1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    idle();
    check("dir_ovr_keep_sub", 32'(snap_if.SNAP_SUB), 2);
    check("dir_ovr_set", 32'(snap_if.SNAP_OVERRUN), 1);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
    idle();
    check("dir_ack_valid", 32'(snap_if.SNAP_VALID), 0);
    check("dir_ack_ovr", 32'(snap_if.SNAP_OVERRUN), 0);

    // EVENT+ACK recapture, then EVENT with SET takes pre-load values.
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 5, 6, 7, 1'b1, 1'b1);
    idle();
    check("dir_evset_valid", 32'(snap_if.SNAP_VALID), 1);
    check("dir_evset_ovr", 32'(snap_if.SNAP_OVERRUN), 0);
    check("dir_evset_sub", 32'(snap_if.SNAP_SUB), 3);
    check("dir_evset_ms", 32'(snap_if.SNAP_MS), 3);
    check("dir_evset_loaded_ms", 32'(CNT_MS), 5);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 39) == 0,
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 15)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    idle();
    repeat (2) @(negedge CLK);
    check("scoreboard_drained", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/real_time_base.md
Name: real_time_base

Overview:
- Parametrised timebase for the telescope gateware. A single clock is divided into a 1 kHz millisecond tick, then cascaded into ms-of-second, second-of-minute and free-running minute counters.
- Provides single-cycle tick pulses and legacy toggle (square-wave) outputs.
- Provides a software-loadable time value.
- Provides an event-timestamp capture register with a valid/ack handshake, so detector coincidences can be tagged with wall-clock time.

Parameters:
CLK_HZ, 9600000, input clock frequency in Hz; must be an integer multiple of TICK_HZ (elaboration-time error otherwise)
TICK_HZ, 1000, base tick rate in Hz; prescaler divisor DIV = CLK_HZ/TICK_HZ, DIV >= 2
TICKS_PER_SEC, 1000, base ticks per second (ms field range 0..TICKS_PER_SEC-1)
MIN_WIDTH, 16, width of the free-running minute counter

Ports:
CLK  in  1  system clock
RST  in  1  synchronous active-high reset
EN  in  1  count enable; when low all counters hold
SET  in  1  single-cycle load strobe for SET_* values
SET_MS  in  10  ms value to load
SET_SEC  in  6  second value to load
SET_MIN  in  MIN_WIDTH  minute value to load
EVENT  in  1  single-cycle, already-synchronised capture strobe
SNAP_ACK  in  1  consumer acknowledge of snapshot
MS_TICK  out  1  one-cycle pulse on ms rollover of prescaler
SEC_TICK  out  1  one-cycle pulse on ms-counter wrap
MIN_TICK  out  1  one-cycle pulse on second-counter wrap
MS_SQ  out  1  toggles on every MS_TICK
SEC_SQ  out  1  toggles on every SEC_TICK
MIN_SQ  out  1  toggles on every MIN_TICK
CNT_MS  out  10  current ms count
CNT_SEC  out  6  current second count
CNT_MIN  out  MIN_WIDTH  current minute count
SNAP_SUB  out  clog2(DIV)  captured prescaler value
SNAP_MS  out  10  captured ms
SNAP_SEC  out  6  captured seconds
SNAP_MIN  out  MIN_WIDTH  captured minutes
SNAP_VALID  out  1  snapshot holds unread data
SNAP_OVERRUN  out  1  an EVENT was dropped while SNAP_VALID was high

Behaviour:
- Reset: while RST is high at a CLK edge, all outputs, counters and the prescaler go to 0. RST overrides SET, EN and EVENT.
- Prescaler:
  - Counts 0..DIV-1 while EN=1.
  - At DIV-1 it returns to 0, and MS_TICK is high during that same cycle (combinational decode of prescaler==DIV-1 && EN, or registered one cycle early; either way the pulse coincides with the edge at which CNT_MS advances).
- Cascade:
  - CNT_MS increments on MS_TICK and wraps TICKS_PER_SEC-1 -> 0; SEC_TICK is high in that cycle.
  - CNT_SEC wraps 59 -> 0 on SEC_TICK; MIN_TICK is high in that cycle.
  - CNT_MIN increments on MIN_TICK and wraps 2^MIN_WIDTH-1 -> 0 silently.
  - All three ticks may be high in the same cycle.
- Square outputs: each *_SQ inverts at the edge ending a cycle where its tick is high.
- EN=0: prescaler, counters and *_SQ hold; all ticks are 0.
- SET (priority over counting, below RST):
  - Loads CNT_MS/SEC/MIN and clears the prescaler. No ticks are asserted that cycle; *_SQ are unchanged.
  - Out-of-range values saturate: SET_MS > TICKS_PER_SEC-1 loads TICKS_PER_SEC-1; SET_SEC > 59 loads 59.
- Capture:
  - EVENT with SNAP_VALID=0: SNAP_* latch the values of the prescaler and CNT_* present in that cycle (pre-increment). SNAP_VALID=1 from the next cycle.
  - SNAP_ACK with SNAP_VALID=1 clears SNAP_VALID and SNAP_OVERRUN next cycle. SNAP_ACK while invalid is ignored.
  - EVENT while SNAP_VALID=1 and no SNAP_ACK: the snapshot is kept and SNAP_OVERRUN is set (sticky until ACK or RST).
  - EVENT and SNAP_ACK in the same cycle while valid: a new capture occurs, SNAP_VALID stays 1 and SNAP_OVERRUN clears.
  - EVENT in the same cycle as SET captures the pre-load values.
  - Capture works regardless of EN.
- Latency: counters and snapshot registers are updated one clock edge after the causing condition. There is no combinational path from EVENT/SNAP_ACK to outputs.

Decomposition:
- Shared package `rtb_pkg`:
  - constants SEC_PER_MIN=60, MS_W=10, SEC_W=6
  - function clog2
  - elaboration checks
- Sub-module `mod_n_counter`:
  - parameters N and WIDTH
  - ports CLK, RST, INC, LOAD, LOAD_VAL (saturated to N-1), CNT, WRAP
  - instantiated for the prescaler (N=DIV), ms, sec and min (N=2^MIN_WIDTH).
- Capture/handshake logic stays in the top module.

Test Plan (CLK_HZ=40, TICK_HZ=10, TICKS_PER_SEC=10, MIN_WIDTH=4 ⇒ DIV=4):
- Reset, then EN=1 for 4 cycles -> exactly one MS_TICK on cycle 4, CNT_MS=1 after it, MS_SQ=1; RST mid-count -> all outputs 0 next edge.
- Run 40 cycles from 0 -> SEC_TICK once, CNT_MS=0, CNT_SEC=1, SEC_SQ=1; EN=0 for 10 cycles holds all values, no ticks.
- SET with MS=9, SEC=59, MIN=15, then 4 cycles -> MS_TICK, SEC_TICK and MIN_TICK coincide; counters become 0/0/0 (minute wrap).
- SET with MS=12, SEC=63 -> CNT_MS=9, CNT_SEC=59; prescaler=0; no tick that cycle.
- EVENT at prescaler=2, CNT_MS=3 -> SNAP_SUB=2, SNAP_MS=3, VALID=1 next cycle. Second EVENT before ACK -> snapshot unchanged, OVERRUN=1. ACK -> both cleared.
- EVENT and SNAP_ACK in the same cycle while valid -> new values captured, VALID stays 1, OVERRUN=0; EVENT with SET -> pre-load values captured.
